pkt_rr_arbiter: RTL
===================

// Module: pkt_rr_arbiter
// PURPOSE
// Shares one router input port among NUM_REQ packet generators, each presenting 13-bit
//   packets {EOP, payload[7:0], type[1:0], dest[1:0]} on a valid/ready handshake.
// Round-robin arbitration, plus an urgent override for type==2'b11 that is bounded
//   against starvation. A one-entry output register gives 1-cycle latency at 1 pkt/cycle.
// Sits between the packet_gen instances and the router ingress.
// PARAMETERS
// NUM_REQ    4   number of requesters (2..8)
// PKT_W      13  packet width; type field is packet[3:2]
// URG_LIMIT  2   max consecutive urgent-override grants before a plain RR grant is forced
// PORTS
// clk         in   1                clock, rising edge
// rst         in   1                asynchronous, active-low reset
// req_valid   in   NUM_REQ          per-requester packet valid
// req_packet  in   NUM_REQ*PKT_W    packet i at [i*PKT_W +: PKT_W]
// req_ready   out  NUM_REQ          one-hot (or zero) accept strobe to requesters
// out_valid   out  1                output register holds a packet
// out_packet  out  PKT_W            buffered packet to router
// out_ready   in   1                router accepts out_packet
// grant_id    out  $clog2(NUM_REQ)  source index of the packet in out_packet
// busy        out  1                out_valid | (|req_valid)
// BEHAVIOUR
// - Reset (async, rst=0): out_valid=0, out_packet=0, grant_id=0, rr_ptr=0, urg_ptr=0,
//   urg_cnt=0. A buffered packet is dropped. req_ready is comb-gated to 0 while rst=0.
// - load_en = ~out_valid | out_ready. Comb winner W is valid only when |req_valid.
// - req_ready[W] = load_en & |req_valid; all other bits are 0. A transfer occurs when
//   req_valid[i] & req_ready[i].
// - On transfer, at the next edge: out_packet <= req_packet[W], grant_id <= W,
//   out_valid <= 1. Latency is 1 cycle from accept to out_valid.
// - Output handshake done = out_valid & out_ready. If done and no transfer:
//   out_valid <= 0. If done and transfer in the same cycle, the register reloads
//   back-to-back and out_valid stays 1.
// - While out_valid & ~out_ready: out_packet and grant_id hold stable, and
//   req_ready is all 0.
// - Urgent set U = {i : req_valid[i] & req_packet[i][3:2]==2'b11}.
// - Selection mode URG: chosen when U is non-empty and urg_cnt < URG_LIMIT.
//   W = first member of U searching upward from urg_ptr, wrapping modulo NUM_REQ.
//   On grant: urg_ptr <= W+1 (mod NUM_REQ); urg_cnt <= urg_cnt+1.
// - Otherwise mode RR: W = first valid requester searching upward from rr_ptr (wrap).
//   On grant: rr_ptr <= W+1 (mod NUM_REQ); urg_cnt <= 0.
// - Pointers and urg_cnt change only on a transfer. No requests means no state change.
// - urg_cnt saturates at URG_LIMIT. Width is $clog2(URG_LIMIT+1).
// - A requester dropping req_valid without a transfer is legal. Arbitration
//   re-evaluates every cycle with no grant lock.
// - Packet contents pass through unmodified. The arbiter never inspects dest or EOP.
// TESTING
// 1 Only req0 valid, packet 13'h1A56, out_ready=1 -> req_ready=4'b0001 in cycle 0;
//   next cycle out_valid=1, out_packet=13'h1A56, grant_id=0.
// 2 All 4 valid, type=00, out_ready=1 held -> grant_id sequence 0,1,2,3,0,1 on
//   consecutive cycles; out_valid stays 1.
// 3 Load a packet, then out_ready=0 for 3 cycles -> out_packet/grant_id stable,
//   req_ready=0; out_ready=1 -> next winner loads in the same cycle as drain.
// 4 req0,req1 type 00 and req2 type 11 all held valid, URG_LIMIT=2 ->
//   grants 2,2,0,2,2,1,2,2,2.
// 5 out_valid=1 with out_ready=0, pull rst low mid-cycle -> out_valid=0 immediately;
//   after release, req1 only -> grant_id=1 and rr_ptr becomes 2.
// 6 Random valid/ready/type, 10k cycles -> scoreboard: every accepted packet emerges
//   once, in order. No requester waits > NUM_REQ*(URG_LIMIT+1) grants.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter with bounded urgent override and a one-entry output register.
// Shares one router ingress port among NUM_REQ valid/ready packet sources.
module pkt_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PKT_W     = 13,
    parameter int unsigned URG_LIMIT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PKT_W-1:0]   req_packet,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [PKT_W-1:0]           out_packet,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(URG_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(URG_LIMIT);

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       urg_ptr;
    logic [CNT_W-1:0]       urg_cnt;

    logic [PKT_W-1:0]       pkt [NUM_REQ];
    logic [NUM_REQ-1:0]     urg_set;
    logic [NUM_REQ-1:0]     cand;
    logic [2*NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]       start;
    logic [IDX_W-1:0]       offset;
    logic [IDX_W:0]         sum;
    logic [IDX_W-1:0]       win;
    logic [IDX_W-1:0]       win_next;
    logic                   found;
    logic                   urg_mode;
    logic                   any_valid;
    logic                   load_en;
    logic                   xfer;

    // Unpack requester packets and flag urgent (type 2'b11) requests.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt[i]     = req_packet[i*PKT_W +: PKT_W];
            urg_set[i] = req_valid[i] && (pkt[i][3:2] == 2'b11);
        end
    end

    assign any_valid = |req_valid;
    assign urg_mode  = (|urg_set) && (urg_cnt < CNT_MAX);
    assign cand      = urg_mode ? urg_set : req_valid;
    assign start     = urg_mode ? urg_ptr : rr_ptr;
    assign rot       = {cand, cand} >> start;

    // Rotate candidates so the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                offset = IDX_W'(k);
                found  = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= NREQ_EXT) begin
            sum = sum - NREQ_EXT;
        end
        win = sum[IDX_W-1:0];
    end

    assign win_next = (win == LAST_IDX) ? '0 : win + 1'b1;
    assign load_en  = ~out_valid | out_ready;
    assign xfer     = rst & load_en & any_valid;
    assign busy     = out_valid | any_valid;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win] = 1'b1;
        end
    end

    // Output register plus arbitration state; state only moves on a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_packet <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
            urg_ptr    <= '0;
            urg_cnt    <= '0;
        end else begin
            if (xfer) begin
                out_valid  <= 1'b1;
                out_packet <= pkt[win];
                grant_id   <= win;
                if (urg_mode) begin
                    urg_ptr <= win_next;
                    if (urg_cnt != CNT_MAX) begin
                        urg_cnt <= urg_cnt + 1'b1;
                    end
                end else begin
                    rr_ptr  <= win_next;
                    urg_cnt <= '0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
